// File: rtl/smg_scan_ctrl.sv
//-----------------------------------------------------------------------------
// smg_scan_ctrl
//
// Time-multiplexed scan controller for a bank of common-anode style 7-segment
// digits. One digit is enabled per scan slot; a full frame visits every digit
// once. New content is captured with a single-cycle load strobe into staging
// registers and only promoted to the displayed registers at a frame boundary,
// so a frame never shows a mix of old and new values.
//
// Features: hex decode, per-digit decimal point, per-digit blink,
// leading-zero blanking and PWM brightness within each slot.
//
// Parameters
//   DIGITS    number of multiplexed digits (1..16)
//   CLK_HZ    clk frequency in Hz
//   SCAN_HZ   per-digit slot rate in Hz   (DIV = CLK_HZ / SCAN_HZ cycles/slot)
//   BLINK_HZ  blink rate in Hz            (HB  = CLK_HZ / (2*BLINK_HZ) cycles/phase)
//   PWM_BITS  brightness resolution       (DIV must be >= 2**PWM_BITS)
//
// Ports
//   clk         in   1           system clock, rising edge
//   rst_n       in   1           asynchronous active-low reset
//   number_sig  in   4*DIGITS    hex nibbles, digit i = [4i+3:4i], digit 0 = LSD
//   dp_mask     in   DIGITS      1 = light decimal point of digit i
//   blink_mask  in   DIGITS      1 = digit i blinks
//   blank_lz    in   1           1 = leading-zero blanking enabled
//   bright      in   PWM_BITS    brightness, 0 dimmest, all-ones full on
//   load        in   1           strobe capturing all of the above
//   smg_data    out  8           segments {dp,g,f,e,d,c,b,a}, active-low
//   scan_sig    out  DIGITS      digit enables, active-low, at most one low
//   frame_tick  out  1           one-cycle pulse after the last slot of a frame
//-----------------------------------------------------------------------------
module smg_scan_ctrl #(
    parameter int DIGITS   = 6,
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2,
    parameter int PWM_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   number_sig,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   bright,
    input  logic                  load,
    output logic [7:0]            smg_data,
    output logic [DIGITS-1:0]     scan_sig,
    output logic                  frame_tick
);

    //-------------------------------------------------------------------------
    // Derived constants
    //-------------------------------------------------------------------------
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int HB  = CLK_HZ / (2 * BLINK_HZ);

    localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HBW = (HB > 1) ? $clog2(HB) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // DIV <= 2**PCW, so DIV*(bright+1) <= 2**(PCW+PWM_BITS); one extra bit
    // keeps both sides of the PWM compare free of overflow.
    localparam int PMW = PCW + PWM_BITS + 1;

    localparam logic [PCW-1:0] PCNT_LAST = PCW'(DIV - 1);
    localparam logic [HBW-1:0] HB_LAST   = HBW'(HB - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [PMW-1:0] DIV_W     = PMW'(DIV);

    //-------------------------------------------------------------------------
    // Parameter sanity (elaboration-time)
    //-------------------------------------------------------------------------
    if (DIGITS < 1 || DIGITS > 16) begin : g_chk_digits
        $error("smg_scan_ctrl: DIGITS must be in 1..16");
    end
    if (DIV < (1 << PWM_BITS)) begin : g_chk_div
        $error("smg_scan_ctrl: CLK_HZ/SCAN_HZ must be >= 2**PWM_BITS");
    end
    if (HB < 1) begin : g_chk_hb
        $error("smg_scan_ctrl: CLK_HZ/(2*BLINK_HZ) must be >= 1");
    end

    //-------------------------------------------------------------------------
    // Timebase: slot prescaler, digit index, blink phase
    //-------------------------------------------------------------------------
    logic [PCW-1:0] pcnt_reg;
    logic [IW-1:0]  idx_reg;
    logic [HBW-1:0] hb_cnt_reg;
    logic           phase_reg;
    logic           frame_tick_reg;

    logic slot_tick;
    logic idx_last;
    logic frame_end;
    logic hb_last;

    assign slot_tick = (pcnt_reg == PCNT_LAST);
    assign idx_last  = (idx_reg == IDX_LAST);
    assign frame_end = slot_tick && idx_last;
    assign hb_last   = (hb_cnt_reg == HB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin : p_timebase
        if (!rst_n) begin
            pcnt_reg       <= '0;
            idx_reg        <= '0;
            hb_cnt_reg     <= '0;
            phase_reg      <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            pcnt_reg <= slot_tick ? '0 : pcnt_reg + PCW'(1);
            if (slot_tick) begin
                idx_reg <= idx_last ? '0 : idx_reg + IW'(1);
            end
            hb_cnt_reg <= hb_last ? '0 : hb_cnt_reg + HBW'(1);
            if (hb_last) begin
                phase_reg <= ~phase_reg;
            end
            // Registered so the pulse lands in the cycle after the last slot
            // cycle of the frame.
            frame_tick_reg <= frame_end;
        end
    end

    assign frame_tick = frame_tick_reg;

    //-------------------------------------------------------------------------
    // Staging and display registers
    //-------------------------------------------------------------------------
    logic [4*DIGITS-1:0] stg_num_reg;
    logic [DIGITS-1:0]   stg_dp_reg;
    logic [DIGITS-1:0]   stg_blink_reg;
    logic                stg_lz_reg;
    logic [PWM_BITS-1:0] stg_bright_reg;
    logic                pending_reg;

    logic [4*DIGITS-1:0] dsp_num_reg;
    logic [DIGITS-1:0]   dsp_dp_reg;
    logic [DIGITS-1:0]   dsp_blink_reg;
    logic                dsp_lz_reg;
    logic [PWM_BITS-1:0] dsp_bright_reg;

    always_ff @(posedge clk or negedge rst_n) begin : p_stage
        if (!rst_n) begin
            stg_num_reg    <= '0;
            stg_dp_reg     <= '0;
            stg_blink_reg  <= '0;
            stg_lz_reg     <= 1'b0;
            stg_bright_reg <= '1;
            pending_reg    <= 1'b0;
        end else begin
            // Last load before the boundary wins.
            if (load) begin
                stg_num_reg    <= number_sig;
                stg_dp_reg     <= dp_mask;
                stg_blink_reg  <= blink_mask;
                stg_lz_reg     <= blank_lz;
                stg_bright_reg <= bright;
            end
            // A load coinciding with the boundary re-arms pending for the
            // following frame; the display picks up the previous staging.
            if (load) begin
                pending_reg <= 1'b1;
            end else if (frame_end) begin
                pending_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_display
        if (!rst_n) begin
            dsp_num_reg    <= '0;
            dsp_dp_reg     <= '0;
            dsp_blink_reg  <= '0;
            dsp_lz_reg     <= 1'b0;
            dsp_bright_reg <= '1;
        end else if (frame_end && pending_reg) begin
            dsp_num_reg    <= stg_num_reg;
            dsp_dp_reg     <= stg_dp_reg;
            dsp_blink_reg  <= stg_blink_reg;
            dsp_lz_reg     <= stg_lz_reg;
            dsp_bright_reg <= stg_bright_reg;
        end
    end

    //-------------------------------------------------------------------------
    // Per-digit nibble extraction and blanking
    //-------------------------------------------------------------------------
    logic [3:0]        dsp_nib [DIGITS];
    logic [DIGITS-1:0] lz_zero;
    logic [DIGITS-1:0] dark;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign dsp_nib[gi] = dsp_num_reg[4*gi +: 4];

            // A digit is a leading zero when it and every more significant
            // nibble are zero; the least significant digit always shows.
            if (gi == 0) begin : g_lsd
                assign lz_zero[gi] = 1'b0;
            end else begin : g_upper
                assign lz_zero[gi] = (dsp_num_reg[4*DIGITS-1:4*gi] == '0);
            end

            assign dark[gi] = (dsp_lz_reg & lz_zero[gi])
                            | (phase_reg & dsp_blink_reg[gi]);
        end
    endgenerate

    //-------------------------------------------------------------------------
    // Segment decode, active-low {dp,g,f,e,d,c,b,a}, dp off
    //-------------------------------------------------------------------------
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        pat = 8'hFF;
        case (nib)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            4'hF: pat = 8'h8E;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    //-------------------------------------------------------------------------
    // PWM gate: drive only while pcnt * 2**PWM_BITS < DIV * (bright + 1)
    //-------------------------------------------------------------------------
    logic [PMW-1:0] pwm_lhs;
    logic [PMW-1:0] pwm_rhs;
    logic           pwm_on;

    assign pwm_lhs = PMW'(pcnt_reg) << PWM_BITS;
    assign pwm_rhs = DIV_W * (PMW'(dsp_bright_reg) + PMW'(1));
    assign pwm_on  = (pwm_lhs < pwm_rhs);

    //-------------------------------------------------------------------------
    // Output stage: computed from the current pcnt/idx, registered so the
    // pins change only on clock edges and lag the counters by one cycle.
    //-------------------------------------------------------------------------
    logic [7:0]        smg_next;
    logic [DIGITS-1:0] scan_next;
    logic [7:0]        smg_reg;
    logic [DIGITS-1:0] scan_reg;

    always_comb begin : p_out_next
        smg_next  = 8'hFF;
        scan_next = '1;
        if (!dark[idx_reg] && pwm_on) begin
            smg_next = seg_decode(dsp_nib[idx_reg]);
            if (dsp_dp_reg[idx_reg]) begin
                smg_next[7] = 1'b0;
            end
            scan_next[idx_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_out_reg
        if (!rst_n) begin
            smg_reg  <= 8'hFF;
            scan_reg <= '1;
        end else begin
            smg_reg  <= smg_next;
            scan_reg <= scan_next;
        end
    end

    assign smg_data = smg_reg;
    assign scan_sig = scan_reg;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
//-----------------------------------------------------------------------------
// tb_smg_scan_ctrl
//
// Scoreboard bench for smg_scan_ctrl with DIGITS=4, DIV=10, HB=100,
// PWM_BITS=3. The stimulus process pushes one expected record per scan slot
// (10 output cycles); the monitor summarises each observed slot (lit value,
// lit cycle count, frame_tick position, shape) and pops/compares.
//
// cyc counts rising edges since reset release. Output cycle k (k>=1) shows
// slot (k-1)/10, slot position (k-1)%10. A load driven when cyc==j is sampled
// with pcnt=j%10, idx=(j/10)%4. Blink phase in slot s is (s/10)%2.
//-----------------------------------------------------------------------------
module tb_smg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int CLK_HZ   = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int BLINK_HZ = 5;
    localparam int PWM_BITS = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [15:0]         number_sig = '0;
    logic [3:0]          dp_mask = '0;
    logic [3:0]          blink_mask = '0;
    logic                blank_lz = 1'b0;
    logic [2:0]          bright = '0;
    logic                load = 1'b0;
    logic [7:0]          smg_data;
    logic [3:0]          scan_sig;
    logic                frame_tick;

    smg_scan_ctrl #(
        .DIGITS  (DIGITS),
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .BLINK_HZ(BLINK_HZ),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .number_sig(number_sig),
        .dp_mask   (dp_mask),
        .blink_mask(blink_mask),
        .blank_lz  (blank_lz),
        .bright    (bright),
        .load      (load),
        .smg_data  (smg_data),
        .scan_sig  (scan_sig),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] scan;
        logic [7:0] smg;
        int         lit;
        int         ft;
    } slot_t;

    slot_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;

    // Rising edges since reset release.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) cyc = 0;
            else        cyc = cyc + 1;
        end
    end

    //-------------------------------------------------------------------------
    // Expectation helpers. Pattern 8'hFF marks a dark slot.
    //-------------------------------------------------------------------------
    task automatic push_one(input logic [3:0] scan, input logic [7:0] pat,
                            input int lit, input int ft);
        slot_t s;
        if (pat == 8'hFF) begin
            s.scan = 4'hF;
            s.smg  = 8'hFF;
            s.lit  = 0;
        end else begin
            s.scan = scan;
            s.smg  = pat;
            s.lit  = lit;
        end
        s.ft = ft;
        exp_q.push_back(s);
    endtask

    task automatic push_frame(input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3,
                              input int lit);
        push_one(4'b1110, p0, lit, 0);
        push_one(4'b1101, p1, lit, 0);
        push_one(4'b1011, p2, lit, 0);
        push_one(4'b0111, p3, lit, 1);
    endtask

    task automatic at_cycle(input int j);
        while (cyc < j) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input int j, input logic [15:0] num,
                           input logic [3:0] dp, input logic [3:0] bl,
                           input logic lz, input logic [2:0] br);
        at_cycle(j);
        number_sig = num;
        dp_mask    = dp;
        blink_mask = bl;
        blank_lz   = lz;
        bright     = br;
        load       = 1'b1;
        $display("load  cycle %0d: number=%h dp=%b blink=%b lz=%b bright=%0d",
                 j, num, dp, bl, lz, br);
        at_cycle(j + 1);
        load = 1'b0;
    endtask

    //-------------------------------------------------------------------------
    // Monitor: one compare per completed slot, reset-state compare in reset
    //-------------------------------------------------------------------------
    initial begin
        int         pos;
        int         lit_cnt;
        int         ft_cnt;
        bit         ft_last;
        bit         shape_ok;
        int         ft_code;
        logic [3:0] obs_scan;
        logic [7:0] obs_smg;
        slot_t      e;
        lit_cnt = 0; ft_cnt = 0; ft_last = 0; shape_ok = 1;
        obs_scan = 4'hF; obs_smg = 8'hFF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_cmp++;
                if (smg_data !== 8'hFF || scan_sig !== 4'hF || frame_tick !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_state: got smg=%h scan=%b ft=%b, expected smg=ff scan=1111 ft=0",
                             smg_data, scan_sig, frame_tick);
                end
                lit_cnt = 0; ft_cnt = 0; ft_last = 0; shape_ok = 1;
                obs_scan = 4'hF; obs_smg = 8'hFF;
            end else if (cyc > 0) begin
                pos = (cyc - 1) % 10;
                if (pos == 0) begin
                    lit_cnt = 0; ft_cnt = 0; ft_last = 0; shape_ok = 1;
                    obs_scan = 4'hF; obs_smg = 8'hFF;
                end
                if (scan_sig !== 4'hF) begin
                    if (lit_cnt == 0) begin
                        obs_scan = scan_sig;
                        obs_smg  = smg_data;
                    end else if (scan_sig !== obs_scan || smg_data !== obs_smg) begin
                        shape_ok = 0;
                    end
                    // Lit cycles must form one run starting at slot position 0.
                    if (lit_cnt != pos) shape_ok = 0;
                    lit_cnt++;
                end else if (smg_data !== 8'hFF) begin
                    shape_ok = 0;
                end
                if (frame_tick === 1'b1) begin
                    ft_cnt++;
                    if (pos == 9) ft_last = 1;
                end else if (frame_tick !== 1'b0) begin
                    shape_ok = 0;
                end
                if (pos == 9 && exp_q.size() > 0) begin
                    ft_code = (ft_cnt == 0) ? 0 : ((ft_cnt == 1 && ft_last) ? 1 : 2);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (obs_scan !== e.scan || obs_smg !== e.smg || lit_cnt != e.lit ||
                        ft_code != e.ft || !shape_ok) begin
                        n_bad++;
                        $display("FAIL slot %0d: got scan=%b smg=%h lit=%0d ft=%0d shape=%0d, expected scan=%b smg=%h lit=%0d ft=%0d shape=1",
                                 (cyc - 1) / 10, obs_scan, obs_smg, lit_cnt, ft_code, shape_ok,
                                 e.scan, e.smg, e.lit, e.ft);
                    end else begin
                        $display("slot  %0d: scan=%b smg=%h lit=%0d ft=%0d",
                                 (cyc - 1) / 10, obs_scan, obs_smg, lit_cnt, ft_code);
                    end
                end
            end
        end
    end

    //-------------------------------------------------------------------------
    // Stimulus
    //-------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // Idle after reset: all digits show 0, full brightness.
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 10);    // frame 0
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 10);    // frame 1
        rst_n = 1'b1;

        // Load mid-frame (idx=1): frame 2 keeps old content.
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 10);    // frame 2
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9, 10);    // frame 3: F A 2 1
        do_load(92, 16'h12AF, 4'b0000, 4'b0000, 1'b0, 3'd7);

        // Leading-zero blanking. 0x0050: digit1 holds 5, digit0 is 0.
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9, 10);    // frame 4
        push_frame(8'hC0, 8'h92, 8'hFF, 8'hFF, 10);    // frame 5
        do_load(165, 16'h0050, 4'b0000, 4'b0000, 1'b1, 3'd7);
        push_frame(8'hC0, 8'h92, 8'hFF, 8'hFF, 10);    // frame 6
        push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 10);    // frame 7: only digit0
        do_load(245, 16'h0000, 4'b0000, 4'b0000, 1'b1, 3'd7);

        // Brightness: bright=0 -> pcnt 0..1 lit; bright=3 -> pcnt 0..4 lit.
        push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 10);    // frame 8
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 2);     // frame 9
        do_load(325, 16'h3210, 4'b0000, 4'b0000, 1'b0, 3'd0);
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 2);     // frame 10
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 5);     // frame 11
        do_load(405, 16'h3210, 4'b0000, 4'b0000, 1'b0, 3'd3);

        // Blink digit0 and dp on digit1 ('1' with dp -> 79).
        // Slots 52..59 are blink phase 1, slots 60..67 phase 0.
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 5);     // frame 12
        push_frame(8'hFF, 8'h79, 8'hA4, 8'hB0, 10);    // frame 13
        push_frame(8'hFF, 8'h79, 8'hA4, 8'hB0, 10);    // frame 14
        push_frame(8'hC0, 8'h79, 8'hA4, 8'hB0, 10);    // frame 15
        do_load(485, 16'h3210, 4'b0010, 4'b0001, 1'b0, 3'd7);

        // Two loads in frame 16, last wins; then a pending load lost to reset.
        push_frame(8'hC0, 8'h79, 8'hA4, 8'hB0, 10);    // frame 16
        push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4, 10);    // frame 17
        push_one(4'b1110, 8'hA4, 10, 0);               // frame 18 digit0
        do_load(645, 16'h1111, 4'b0000, 4'b0000, 1'b0, 3'd7);
        do_load(655, 16'h2222, 4'b0000, 4'b0000, 1'b0, 3'd7);
        do_load(725, 16'h3333, 4'b0000, 4'b0000, 1'b0, 3'd7);

        at_cycle(735);
        rst_n      = 1'b0;
        number_sig = '0;
        dp_mask    = '0;
        blink_mask = '0;
        blank_lz   = 1'b0;
        bright     = '0;
        $display("reset cycle 735: asserted mid-slot with a load pending");
        repeat (3) @(posedge clk);
        #2;
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 10);    // frame 0 after reset
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 10);    // frame 1: nothing pending
        rst_n = 1'b1;

        for (int w = 0; w < 3000 && exp_q.size() != 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d slots still expected, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #60000;
        n_bad++;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
